// File: rtl/coin_input_conditioner.sv
// Coin/return input front end: two-flop sync, debounce FSM per channel,
// then a fixed-priority serialiser that emits at most one pulse per cycle.
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_coin_5,
  input  logic raw_coin_10,
  input  logic raw_coin_25,
  input  logic raw_return_btn,
  input  logic accept_en,
  output logic coin_5,
  output logic coin_10,
  output logic coin_25,
  output logic coin_return,
  output logic coin_reject,
  output logic busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, DB_HIGH, HELD, DB_LOW} state_t;

  // Channel index: 0 = 5c, 1 = 10c, 2 = 25c, 3 = return.
  logic [3:0]    raw;
  logic [3:0]    s1, s2;
  state_t        state [4];
  state_t        state_nxt [4];
  logic [CW-1:0] cnt [4];
  logic [CW-1:0] cnt_nxt [4];
  logic [3:0]    qual, accepted, grant, pend, pend_nxt;
  logic [2:0]    rejects;
  logic [1:0]    rej_cnt, rej_nxt;
  logic [2:0]    rej_sum;
  logic          any_active;

  assign raw = {raw_return_btn, raw_coin_25, raw_coin_10, raw_coin_5};

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      qual[i]      = 1'b0;
      case (state[i])
        IDLE: begin
          if (s2[i]) begin
            state_nxt[i] = DB_HIGH;
            cnt_nxt[i]   = CW'(1);
          end
        end
        DB_HIGH: begin
          if (s2[i]) begin
            if (cnt[i] + CW'(1) == LIMIT) begin
              state_nxt[i] = HELD;
              cnt_nxt[i]   = '0;
              qual[i]      = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] + CW'(1);
            end
          end else begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end
        end
        HELD: begin
          if (!s2[i]) begin
            state_nxt[i] = DB_LOW;
            cnt_nxt[i]   = CW'(1);
          end
        end
        DB_LOW: begin
          if (!s2[i]) begin
            if (cnt[i] + CW'(1) == LIMIT) begin
              state_nxt[i] = IDLE;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + CW'(1);
            end
          end else begin
            state_nxt[i] = HELD;
            cnt_nxt[i]   = '0;
          end
        end
        default: begin
          state_nxt[i] = IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    accepted = qual & {1'b1, {3{accept_en}}};
    rejects  = qual[2:0] & {3{~accept_en}};

    grant = '0;
    if (pend[2])      grant = 4'b0100;
    else if (pend[1]) grant = 4'b0010;
    else if (pend[0]) grant = 4'b0001;
    else if (pend[3]) grant = 4'b1000;

    pend_nxt = (pend & ~grant) | accepted;

    // Drain one queued reject per cycle while adding this edge's new ones.
    rej_sum = {1'b0, rej_cnt} - {2'b00, rej_cnt != 2'd0}
            + {2'b00, rejects[0]} + {2'b00, rejects[1]} + {2'b00, rejects[2]};
    rej_nxt = (rej_sum > 3'd3) ? 2'd3 : rej_sum[1:0];

    any_active = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (state[i] != IDLE) any_active = 1'b1;
    end
  end

  assign busy = any_active | (|pend) | (rej_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      pend        <= '0;
      rej_cnt     <= '0;
      coin_5      <= 1'b0;
      coin_10     <= 1'b0;
      coin_25     <= 1'b0;
      coin_return <= 1'b0;
      coin_reject <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1          <= raw;
      s2          <= s1;
      pend        <= pend_nxt;
      rej_cnt     <= rej_nxt;
      coin_5      <= grant[0];
      coin_10     <= grant[1];
      coin_25     <= grant[2];
      coin_return <= grant[3];
      coin_reject <= (rej_cnt != 2'd0);
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

Front-end stage that sits directly upstream of `vending_machine`. It takes raw, asynchronous, bouncy coin-sensor and return-button signals and turns them into the clean single-cycle `coin_5` / `coin_10` / `coin_25` / `coin_return` pulses that the vending machine consumes. It does this by synchronising, debouncing, edge-qualifying and serialising each input. It guarantees at most one output pulse per cycle, and it rejects coins while the downstream machine is locked out.

## Interface
- `DEBOUNCE_CYCLES`, default 4, range 4..255: number of consecutive stable synchronised samples required to qualify a press or a release.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `raw_coin_5` input 1: asynchronous 5¢ sensor, active high.
- `raw_coin_10` input 1: asynchronous 10¢ sensor, active high.
- `raw_coin_25` input 1: asynchronous 25¢ sensor, active high.
- `raw_return_btn` input 1: asynchronous coin-return button, active high.
- `accept_en` input 1: synchronous; 1 means coins may be accepted.
- `coin_5` output 1: single-cycle qualified 5¢ pulse, registered.
- `coin_10` output 1: single-cycle qualified 10¢ pulse, registered.
- `coin_25` output 1: single-cycle qualified 25¢ pulse, registered.
- `coin_return` output 1: single-cycle return-request pulse, registered.
- `coin_reject` output 1: single-cycle pulse; a coin qualified while `accept_en`=0 and was dropped.
- `busy` output 1: high while any channel is not IDLE or any pending bit is set.

## Operation
- Four identical channels, one per raw input. Each channel has:
  - a two-flop synchroniser (`s1` → `s2`);
  - a debounce counter of width clog2(DEBOUNCE_CYCLES+1);
  - a 4-state FSM;
  - one pending bit.
- FSM states and transitions:
  - IDLE: on `s2`=1, go to DB_HIGH with cnt=1.
  - DB_HIGH: on `s2`=1, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to HELD and qualify. On `s2`=0, go to IDLE with cnt=0 (glitch discarded).
  - HELD: on `s2`=0, go to DB_LOW with cnt=1. Holding the input high never re-qualifies.
  - DB_LOW: on `s2`=0, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE. On `s2`=1, go to HELD with cnt=0.
- Qualification:
  - Coin channel with `accept_en`=1 (sampled on the qualifying edge): set that channel's pending bit.
  - Coin channel with `accept_en`=0: set the reject request and leave the pending bit clear.
  - Return channel: always sets its pending bit; it ignores `accept_en`.
- Output arbiter:
  - Each cycle, emit exactly one pending channel, in priority order 25 > 10 > 5 > return.
  - Register the chosen output high for one cycle and clear its pending bit.
  - `coin_reject` is independent of the arbiter and may coincide with a coin pulse.
  - If two or more coins reject on the same edge, `coin_reject` pulses once per coin on consecutive cycles. Use a 2-bit reject counter, saturating at 3.
- Overflow cannot occur:
  - Re-qualifying a channel requires a release plus a press, which takes at least 2·DEBOUNCE_CYCLES ≥ 8 edges.
  - The pending set drains in at most 4 cycles.
- `busy` = any FSM ≠ IDLE OR any pending bit set OR reject count ≠ 0. It is combinational from registers.

## Timing
- Reset (`rst`=1 at a rising edge) clears everything: synchronisers, counters, FSMs (to IDLE), pending bits, reject count, and all outputs (`coin_*`, `coin_return`, `coin_reject`, `busy` = 0).
- Reset mid-debounce discards all partial state; no pulse is generated for the interrupted press.
- A raw input still held high when reset releases is treated as a fresh insertion.
- Latency with no contention: raw first sampled high at edge 1 → `s2`=1 after edge 2 → qualify on edge 2+DEBOUNCE_CYCLES → output high after edge 3+DEBOUNCE_CYCLES, for exactly one cycle. With DEBOUNCE_CYCLES=4 this is edge 7.
- Contention adds one cycle per higher-priority pending channel.
- `coin_reject` follows the same latency as a coin pulse, with no arbiter delay.
- Output pulses are mutually exclusive among `coin_5`, `coin_10`, `coin_25` and `coin_return`. This matches the downstream machine, which adds one coin per cycle.

## Test plan
- Clean `raw_coin_10` high for 12 cycles, DEBOUNCE_CYCLES=4, `accept_en`=1 → `coin_10`=1 for exactly one cycle, after edge 7. No other outputs; `busy` returns to 0 after release debounce completes.
- Bounce: `raw_coin_5` goes 1,0,1,0 on successive cycles, then stays 1 for 10 cycles → exactly one `coin_5` pulse, 7 edges after the final rise. No pulse is produced from the glitches.
- `raw_coin_25` and `raw_coin_5` rise on the same edge and both stay high → `coin_25` after edge 7, `coin_5` after edge 8. They are never asserted together.
- `accept_en`=0 with a clean `raw_coin_10` press → `coin_reject` for one cycle after edge 7; `coin_10` stays 0.
  - `raw_return_btn` pressed in the same window → `coin_return` is still produced.
- `raw_return_btn` held for 30 cycles → exactly one `coin_return` pulse. A second press after ≥4 low cycles → a second pulse.
- `rst` asserted on edge 5 of a `raw_coin_10` press, then released with raw still high → no pulse from the first press; one `coin_10` pulse 7 edges after reset release; all outputs are 0 during reset.
